pipe_sel_mux: RTL and testbench
===============================

Name: pipe_sel_mux

Overview:
Parametrised N-way, WIDTH-bit select mux with a registered output stage and a valid/ready handshake. It is the pipelined successor of the datapath's 2:1 word mux. It is used where operand or writeback selection must cross a pipeline boundary with backpressure, for example ALU source select feeding a stalled EX stage. Input index 0 corresponds to the legacy data0 and index 1 to data1, so NUM_IN=2 with WIDTH=32 is a drop-in registered replacement.

Parameters:
WIDTH, 32, bits per data word
NUM_IN, 4, number of input words (2..16)
SEL_W, derived localparam = max(1, clog2(NUM_IN)), select width (not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
data_in  input  NUM_IN*WIDTH  flattened inputs; word i = data_in[i*WIDTH +: WIDTH]
select  input  SEL_W  index of the word to forward
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat this cycle
flush  input  1  synchronous pipeline flush
data_out  output  WIDTH  selected word, registered
out_valid  output  1  data_out valid
out_ready  input  1  downstream accepts data_out
sel_err  output  1  beat on data_out was captured with select >= NUM_IN

Behaviour:
- Reset: on a clk edge with rst_n=0, all state is cleared. data_out=0, out_valid=0, sel_err=0, internal skid state empty. in_ready=0 while rst_n=0.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge. select and data_in are sampled only at that edge.
- Latency: 1 cycle. An accepted beat appears on data_out/out_valid the next cycle, provided the output register is free or draining.
- Output transfer: a beat is transferred when out_valid && out_ready. While out_valid=1 && out_ready=0, data_out, sel_err and out_valid are held stable.
- Select decode: select < NUM_IN forwards word[select] with sel_err=0. select >= NUM_IN (only possible when NUM_IN is not a power of 2) captures data_out=0 and sel_err=1. sel_err is beat-aligned, not sticky.
- Flush: flush=1 at an edge clears out_valid and skid-valid. data registers may keep stale values.
  - flush beats a simultaneous accept; the input beat is dropped.
  - in_ready behaves normally in the cycle after a flush.
- Simultaneous transfer and accept when the output register is full: the new beat replaces it in the same edge, with no bubble.
- Reset mid-operation overrides flush and all handshakes; pending beats are lost.
- No combinational path from data_in/select to data_out.

Optional Feature:
PIPE_SEL_MUX_SKID_EN
- Defined: 2-entry stage (output register plus skid register). in_ready is a registered signal equal to !skid_valid, with no combinational path from out_ready. When out_valid && !out_ready and a beat is accepted, the beat goes to skid. When the output drains, skid moves to the output register next. Full throughput, in-order delivery.
- Undefined: single output register. in_ready = !out_valid || out_ready (combinational). Same 1-cycle latency and full throughput, but a combinational ready path.

Test Plan:
- NUM_IN=4, WIDTH=32, words 0x11111111..0x44444444, select=2, in_valid=1, out_ready=1 -> next cycle data_out=0x33333333, out_valid=1, sel_err=0.
- NUM_IN=3, select=3, in_valid=1 -> next cycle data_out=0x00000000, sel_err=1. Following beat with select=0 -> sel_err=0.
- Stream of 8 beats with select cycling 0..3 and out_ready=1 -> 8 outputs in order, one per cycle, no bubbles.
- out_ready held 0 for 3 cycles with in_valid=1:
  - SKID_EN defined: exactly 2 beats accepted, then in_ready=0.
  - Undefined: 1 beat accepted.
  - Release out_ready -> all accepted beats delivered in order, with no loss or duplication.
- flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input beat dropped, skid empty.
- rst_n=0 for one edge mid-stream with out_valid=1 -> data_out=0, out_valid=0, sel_err=0, in_ready=0 during reset. After release, the first beat has 1-cycle latency.

Source files
------------

// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: registered N-way WIDTH-bit word select with valid/ready handshake
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   data_in    NUM_IN flattened words, word i = data_in[i*WIDTH +: WIDTH]
//   select     index of the word to forward
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat this cycle
//   flush      synchronous pipeline flush (drops held and incoming beats)
//   data_out   selected word, registered
//   out_valid  data_out valid
//   out_ready  downstream accepts data_out
//   sel_err    beat on data_out was captured with select >= NUM_IN
// Build option: define PIPE_SEL_MUX_SKID_EN for a two-entry stage (output plus
// skid register) whose in_ready is registered; otherwise a single output
// register with a combinational ready path.
module pipe_sel_mux #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  logic [WIDTH-1:0] word;
  logic bad, acc;
  // An out-of-range select matches no word, leaving word at zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++) word = (32'(select) == i) ? data_in[i*WIDTH +: WIDTH] : word;
  end
  assign bad = 32'(select) >= NUM_IN;
  assign acc = in_valid && in_ready;
`ifdef PIPE_SEL_MUX_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic skid_valid, skid_err, drain;
  assign drain = !out_valid || out_ready;
  // Ready depends only on registered skid occupancy, never on out_ready.
  assign in_ready = rst_n && !skid_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      out_valid <= 1'b0;
      sel_err <= 1'b0;
      skid_data <= '0;
      skid_valid <= 1'b0;
      skid_err <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      // A full skid implies in_ready was low, so acc and skid_valid never coincide.
      out_valid <= skid_valid || acc;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        data_out <= skid_data;
        sel_err <= skid_err;
      end else if (acc) begin
        data_out <= word;
        sel_err <= bad;
      end
    end else if (acc) begin
      skid_data <= word;
      skid_err <= bad;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = rst_n && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      out_valid <= 1'b0;
      sel_err <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      data_out <= word;
      sel_err <= bad;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_sel_mux.sv
// tb_pipe_sel_mux: checks a 4-way and a 3-way pipe_sel_mux driven in lockstep
module tb_pipe_sel_mux;
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] d4;
    logic [31:0] d3;
    logic        e3;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [1:0] select = '0;
  logic [127:0] data_in;
  logic in_ready4, in_ready3, out_valid4, out_valid3, sel_err4, sel_err3;
  logic [31:0] data_out4, data_out3;
  vec_t cur = '0;
  vec_t q[$];
  vec_t tbl[8];
  int checks = 0, errors = 0, xfers = 0;
  always #5 clk = ~clk;
  assign data_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select), .in_valid(in_valid),
    .in_ready(in_ready4), .flush(flush), .data_out(data_out4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4));
  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[95:0]), .select(select), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .data_out(data_out3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) q.delete();
    else begin
      if (out_valid4 && out_ready) begin
        xfers++;
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_data4", data_out4, e.d4);
          chk("sb_err4", {31'd0, sel_err4}, 32'd0);
          chk("sb_data3", data_out3, e.d3);
          chk("sb_err3", {31'd0, sel_err3}, {31'd0, e.e3});
          chk("sb_valid3", {31'd0, out_valid3}, 32'd1);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready4) q.push_back(cur);
    end
  end
  initial begin
    int n, k, x0, exp_acc;
    tbl[0] = '{2'd0, 32'h11111111, 32'h11111111, 1'b0};
    tbl[1] = '{2'd1, 32'h22222222, 32'h22222222, 1'b0};
    tbl[2] = '{2'd2, 32'h33333333, 32'h33333333, 1'b0};
    tbl[3] = '{2'd3, 32'h44444444, 32'h00000000, 1'b1};
    tbl[4] = '{2'd0, 32'h11111111, 32'h11111111, 1'b0};
    tbl[5] = '{2'd1, 32'h22222222, 32'h22222222, 1'b0};
    tbl[6] = '{2'd2, 32'h33333333, 32'h33333333, 1'b0};
    tbl[7] = '{2'd3, 32'h44444444, 32'h00000000, 1'b1};
`ifdef PIPE_SEL_MUX_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    step();
    step();
    chk("rst_data", data_out4, 32'h0);
    chk("rst_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_err", {31'd0, sel_err3}, 32'd0);
    chk("rst_ready", {31'd0, in_ready4}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    // single beat, select=2
    cur = tbl[2]; select = cur.sel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel2_valid", {31'd0, out_valid4}, 32'd1);
    chk("sel2_data", data_out4, 32'h33333333);
    chk("sel2_err", {31'd0, sel_err4}, 32'd0);
    step();
    // out-of-range select on the 3-way instance, then back in range
    cur = tbl[3]; select = cur.sel; in_valid = 1'b1;
    step();
    chk("oor_data3", data_out3, 32'h0);
    chk("oor_err3", {31'd0, sel_err3}, 32'd1);
    chk("oor_data4", data_out4, 32'h44444444);
    cur = tbl[0]; select = cur.sel;
    step();
    in_valid = 1'b0;
    chk("ok_err3", {31'd0, sel_err3}, 32'd0);
    chk("ok_data3", data_out3, 32'h11111111);
    step();
    // 8-beat stream, no bubbles
    x0 = xfers;
    for (int i = 0; i < 8; i++) begin
      cur = tbl[i]; select = cur.sel; in_valid = 1'b1;
      step();
      chk("stream_valid", {31'd0, out_valid4}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", xfers - x0, 32'd8);
    // backpressure: out_ready low for 3 cycles
    out_ready = 1'b0;
    n = 0; k = 0;
    for (int c = 0; c < 3; c++) begin
      cur = tbl[k]; select = cur.sel; in_valid = 1'b1;
      #1;
      if (in_ready4) begin n++; k++; end
      step();
    end
    chk("bp_accepted", n, exp_acc);
    chk("bp_ready", {31'd0, in_ready4}, 32'd0);
    in_valid = 1'b0;
    x0 = xfers;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("bp_delivered", xfers - x0, n);
    chk("bp_queue", q.size(), 32'd0);
    // flush with a held beat and an incoming beat
    out_ready = 1'b0;
    cur = tbl[0]; select = cur.sel; in_valid = 1'b1;
    step();
    chk("fl_pre_valid", {31'd0, out_valid4}, 32'd1);
    cur = tbl[1]; select = cur.sel; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid4}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("fl_ready", {31'd0, in_ready4}, 32'd1);
    step();
    chk("fl_skid_empty", {31'd0, out_valid4}, 32'd0);
    // reset mid-stream
    out_ready = 1'b0;
    cur = tbl[3]; select = cur.sel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mr_pre_valid", {31'd0, out_valid4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_ready", {31'd0, in_ready4}, 32'd0);
    step();
    chk("mr_data", data_out4, 32'h0);
    chk("mr_valid", {31'd0, out_valid4}, 32'd0);
    chk("mr_err", {31'd0, sel_err3}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cur = tbl[1]; select = cur.sel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mr_lat_valid", {31'd0, out_valid4}, 32'd1);
    chk("mr_lat_data", data_out4, 32'h22222222);
    step();
    step();
    chk("end_queue", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
